// File: rtl/conway_pkg.sv
// Shared types for the game-of-life core: grid memory operating modes and
// the priority rule that picks one mode from the individual enables.
package conway_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_LOAD,
    MODE_RUN,
    MODE_OUTPUT
  } mem_mode_e;

  // Parallel capture beats serial load, which beats serial read-out.
  function automatic mem_mode_e encode_mode(input logic run_mode,
                                            input logic load_mode,
                                            input logic output_mode);
    if (run_mode)         return MODE_RUN;
    else if (load_mode)   return MODE_LOAD;
    else if (output_mode) return MODE_OUTPUT;
    else                  return MODE_HOLD;
  endfunction

endpackage

// File: rtl/mem_mode_decoder.sv
// Turns the three mode enables into a single grid-memory operating mode.
module mem_mode_decoder
  import conway_pkg::*;
(
  input  logic      run_mode,
  input  logic      load_mode,
  input  logic      output_mode,
  output mem_mode_e mode
);

  assign mode = encode_mode(run_mode, load_mode, output_mode);

endmodule

// File: rtl/system_mem_shift_reg.sv
// Grid state memory: serial load from the host, parallel capture of the next
// generation, and non-destructive serial read-out by rotation.
module system_mem_shift_reg
  import conway_pkg::*;
#(
  parameter int DATA_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] grid_in,
  input  logic                 serial_in,
  input  logic                 load_mode,
  input  logic                 run_mode,
  input  logic                 output_mode,
  output logic [DATA_SIZE-1:0] system_mem_out,
  output logic                 serial_out
);

  logic [DATA_SIZE-1:0] mem;
  mem_mode_e            mode;

  mem_mode_decoder u_mode_decoder (
    .run_mode    (run_mode),
    .load_mode   (load_mode),
    .output_mode (output_mode),
    .mode        (mode)
  );

  // Read-out rotates rather than shifts so the grid survives a full dump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem        <= '0;
      serial_out <= 1'b0;
    end else begin
      serial_out <= 1'b0;
      case (mode)
        MODE_RUN:    mem <= grid_in;
        MODE_LOAD:   mem <= {mem[DATA_SIZE-2:0], serial_in};
        MODE_OUTPUT: begin
          mem        <= {mem[DATA_SIZE-2:0], mem[DATA_SIZE-1]};
          serial_out <= mem[DATA_SIZE-1];
        end
        default:     mem <= mem;
      endcase
    end
  end

  assign system_mem_out = mem;

endmodule

// File: tb/tb_system_mem_shift_reg.sv
// Scoreboard bench for system_mem_shift_reg: directed scenarios followed by
// random mode/data traffic, checked against an arithmetic reference model.
module tb_system_mem_shift_reg;

  localparam int DW = 5;
  typedef logic [DW-1:0] mem_t;

  typedef struct {
    mem_t mem;
    logic so;
    int   id;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  mem_t grid_in;
  logic serial_in;
  logic load_mode;
  logic run_mode;
  logic output_mode;
  mem_t system_mem_out;
  logic serial_out;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   stimId   = 0;

  // Reference model state: the grid as a plain unsigned number.
  int unsigned modelMem = 0;

  system_mem_shift_reg #(.DATA_SIZE(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .grid_in        (grid_in),
    .serial_in      (serial_in),
    .load_mode      (load_mode),
    .run_mode       (run_mode),
    .output_mode    (output_mode),
    .system_mem_out (system_mem_out),
    .serial_out     (serial_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input mem_t gotMem, input logic gotSo,
                             input mem_t expMem, input logic expSo);
    checks++;
    if (gotMem !== expMem || gotSo !== expSo) begin
      failures++;
      $display("[TB] FAIL %s: got mem=%b serial_out=%b, expected mem=%b serial_out=%b",
               name, gotMem, gotSo, expMem, expSo);
    end
  endtask

  // Drive one clock's worth of inputs; optionally pulse reset first, mid-cycle.
  task automatic applyStimulus(input logic rstFirst, input logic run, input logic load,
                               input logic outm, input mem_t grid, input logic sin);
    int unsigned full;
    int unsigned msb;
    exp_t e;
    full = 1 << DW;
    @(negedge clk);
    if (rstFirst) begin
      #1 reset = 1'b1;
      #1 checkOutput("async_reset", system_mem_out, serial_out, '0, 1'b0);
      modelMem = 0;
      #1 reset = 1'b0;
    end
    run_mode    = run;
    load_mode   = load;
    output_mode = outm;
    grid_in     = grid;
    serial_in   = sin;
    e.so = 1'b0;
    if (run) begin
      modelMem = grid;
    end else if (load) begin
      modelMem = (modelMem * 2 + sin) % full;
    end else if (outm) begin
      msb      = modelMem / (full / 2);
      modelMem = (modelMem * 2) % full + msb;
      e.so     = msb[0];
    end
    e.mem = mem_t'(modelMem);
    e.id  = stimId++;
    expQ.push_back(e);
  endtask

  // Monitor: the DUT presents a registered result after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("cycle%0d", e.id), system_mem_out, serial_out, e.mem, e.so);
      end
    end
  end

  initial begin
    int waitCycles;
    reset = 1'b1;
    run_mode = 1'b0; load_mode = 1'b0; output_mode = 1'b0;
    grid_in = '0; serial_in = 1'b0;
    #1 checkOutput("reset_state", system_mem_out, serial_out, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Hold ignores grid_in and serial_in.
    applyStimulus(0, 0, 0, 0, 5'b11001, 1);
    // Serial load 1,0,0,1.
    applyStimulus(0, 0, 1, 0, '0, 1);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 0, '0, 1);
    // Run beats load, then hold twice.
    applyStimulus(0, 1, 1, 0, 5'b00110, 0);
    applyStimulus(0, 0, 0, 0, 5'b11111, 1);
    applyStimulus(0, 0, 0, 0, 5'b10101, 0);
    // Reset pulse, capture 01101, rotate out a full lap.
    applyStimulus(1, 1, 0, 0, 5'b01101, 0);
    for (int i = 0; i < DW; i++) applyStimulus(0, 0, 0, 1, '0, 0);
    // Priority after reset.
    applyStimulus(1, 0, 1, 1, '0, 1);
    applyStimulus(0, 1, 1, 0, 5'b11011, 0);
    applyStimulus(0, 1, 0, 1, 5'b00110, 1);
    // Reset in the middle of a read-out.
    applyStimulus(0, 1, 0, 0, 5'b10110, 0);
    applyStimulus(0, 0, 0, 1, '0, 0);
    applyStimulus(0, 0, 0, 1, '0, 0);
    applyStimulus(1, 0, 0, 1, '0, 0);
    applyStimulus(0, 0, 0, 1, '0, 0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 1),
                    mem_t'($urandom),
                    1'($urandom));
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending results, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
